// File: rtl/wram_arb_pkg.sv
// Shared types and default widths for the weight-RAM arbiter.
//
// owner_t doubles as the arbiter state and as the value reported on the
// arbiter's owner output (0 none, 1 write/loader, 2 read/compute).
package wram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_WR   = 2'd1,
        OWN_RD   = 2'd2
    } owner_t;

    localparam int ADDR_W_DEF = 16;   // covers the 55744-entry conv bank
    localparam int DATA_W_DEF = 8;
    localparam int HOLD_W     = 4;    // hold counter width, MAX_HOLD <= 15

endpackage

// File: rtl/wram_rd_pipe.sv
// Read-valid pipeline for the weight-RAM arbiter.
//
// A read granted in cycle N reaches the RAM address register at edge N+1
// and the RAM returns data one cycle later, so the valid strobe is the
// grant delayed by two register stages. reset clears both stages, which
// drops any read still in flight.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high clear
//   in_valid   read grant of the current cycle
//   out_valid  strobe aligned with the RAM read data
module wram_rd_pipe (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic out_valid
);

    logic [1:0] vld_q;
    logic [1:0] vld_d;

    always_comb begin
        vld_d = {vld_q[0], in_valid};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 2'b00;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[1];

endmodule

// File: rtl/wram_arbiter.sv
// Arbiter sharing one single-port weight RAM between the loader (writes)
// and the compute engine (reads). At most one access is granted per cycle;
// under contention the current owner keeps the RAM for at most MAX_HOLD
// consecutive grants before the other side is served. All RAM control
// signals are registered; read data comes back two cycles after the grant
// together with rd_valid.
//
// Build option: define WRAM_ARB_FIXED_PRIO_EN to make the write side win
// every contended cycle (hold counter removed). Intended for the initial
// load phase while the compute engine is idle.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data     loader write request (held until wr_gnt)
//   wr_gnt                     write accepted this cycle (combinational)
//   rd_req/rd_addr             compute read request (held until rd_gnt)
//   rd_gnt                     read accepted this cycle (combinational)
//   rd_data/rd_valid           read return, 2 cycles after rd_gnt
//   ram_addr/ram_wdata/ram_wren registered RAM controls
//   ram_rdata                  RAM read data, 1 cycle after ram_addr
//   owner                      current owner: 0 none, 1 write, 2 read
module wram_arbiter
    import wram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner
);

    owner_t state_q;
    owner_t state_d;

`ifndef WRAM_ARB_FIXED_PRIO_EN
    // The owner keeps the RAM while hold_cnt is below this limit; the
    // counter starts at 0 on the first grant, so MAX_HOLD grants in a row.
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
`endif

    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] ram_wdata_d;
    logic              ram_wren_q;
    logic              ram_wren_d;

    // ------------------------------------------------------------------
    // Grant decision and next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_gnt  = 1'b0;
        rd_gnt  = 1'b0;
        state_d = OWN_NONE;
`ifndef WRAM_ARB_FIXED_PRIO_EN
        hold_cnt_d = '0;
`endif

        // Grants are suppressed during reset so a requester never sees an
        // acceptance that the cleared state would then forget.
        if (!reset) begin
            if (wr_req && !rd_req) begin
                wr_gnt = 1'b1;
            end else if (rd_req && !wr_req) begin
                rd_gnt = 1'b1;
            end else if (wr_req && rd_req) begin
`ifdef WRAM_ARB_FIXED_PRIO_EN
                wr_gnt = 1'b1;
`else
                case (state_q)
                    OWN_WR: begin
                        if (hold_cnt_q < HOLD_LIMIT) wr_gnt = 1'b1;
                        else                         rd_gnt = 1'b1;
                    end
                    OWN_RD: begin
                        if (hold_cnt_q < HOLD_LIMIT) rd_gnt = 1'b1;
                        else                         wr_gnt = 1'b1;
                    end
                    default: wr_gnt = 1'b1;   // from IDLE the write wins
                endcase
`endif
            end

            if (wr_gnt) state_d = OWN_WR;
            if (rd_gnt) state_d = OWN_RD;

`ifndef WRAM_ARB_FIXED_PRIO_EN
            // Count only repeat grants made while the other side waits;
            // a switch or an uncontended grant restarts the count.
            if ((wr_gnt && state_q == OWN_WR && rd_req) ||
                (rd_gnt && state_q == OWN_RD && wr_req)) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // RAM control registers: address/data hold when nothing is granted
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wren_d  = 1'b0;
        if (wr_gnt) begin
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
            ram_wren_d  = 1'b1;
        end else if (rd_gnt) begin
            ram_addr_d  = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OWN_NONE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
        end
    end

`ifndef WRAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------
    wram_rd_pipe u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_gnt),
        .out_valid (rd_valid)
    );

    // Masked so rd_data stays 0 outside valid cycles (and in reset).
    assign rd_data   = rd_valid ? ram_rdata : '0;

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wren  = ram_wren_q;
    assign owner     = state_q;

endmodule

// File: tb/tb_wram_arbiter.sv
module tb_wram_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk;
    logic        reset;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_gnt;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_gnt;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wren;
    logic [7:0]  ram_rdata;
    logic [1:0]  owner;

    wram_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wren  (ram_wren),
        .ram_rdata (ram_rdata),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // RAM attached to the DUT: 1-cycle read latency
    // ------------------------------------------------------------------
    logic [7:0] tb_mem [0:65535];
    logic [7:0] m_mem  [0:65535];

    always @(posedge clk) begin
        ram_rdata <= tb_mem[ram_addr];
        if (ram_wren) tb_mem[ram_addr] = ram_wdata;
    end

    // ------------------------------------------------------------------
    // Behavioural model: who may own the RAM, how long, and what the
    // registered RAM controls and read returns must look like.
    // owner codes: 0 none, 1 write, 2 read.
    // ------------------------------------------------------------------
    int         m_owner = 0;
    int         m_run   = 0;      // grants in a row to m_owner (contended run)
    bit         m_live  = 0;
    int         cyc     = 0;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_wren;
    int          rdq_cyc[$];
    logic [7:0]  rdq_dat[$];
    int          e_g;             // expected grant this cycle: 0/1/2

    function automatic int model_grant();
        if (reset) return 0;
        if (wr_req && !rd_req) return 1;
        if (rd_req && !wr_req) return 2;
        if (!wr_req && !rd_req) return 0;
`ifdef WRAM_ARB_FIXED_PRIO_EN
        return 1;
`else
        if (m_owner == 0) return 1;
        if (m_run < MAX_HOLD) return m_owner;
        return 3 - m_owner;
`endif
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_live  <= 1'b1;
            m_owner <= 0;
            m_run   <= 0;
            e_addr  <= '0;
            e_wdata <= '0;
            e_wren  <= 1'b0;
            rdq_cyc.delete();
            rdq_dat.delete();
        end else if (e_g == 1) begin
            m_run   <= (m_owner == 1 && rd_req) ? m_run + 1 : 1;
            m_owner <= 1;
            m_mem[wr_addr] = wr_data;
            e_addr  <= wr_addr;
            e_wdata <= wr_data;
            e_wren  <= 1'b1;
        end else if (e_g == 2) begin
            m_run   <= (m_owner == 2 && wr_req) ? m_run + 1 : 1;
            m_owner <= 2;
            rdq_cyc.push_back(cyc);
            rdq_dat.push_back(m_mem[rd_addr]);
            e_addr  <= rd_addr;
            e_wren  <= 1'b0;
        end else begin
            m_owner <= 0;
            m_run   <= 0;
            e_wren  <= 1'b0;
        end
    end

    // Compare process: every cycle once the first reset has been seen.
    always @(negedge clk) begin
        e_g = model_grant();
        if (m_live) begin
            chk("wr_gnt", {31'd0, wr_gnt}, {31'd0, e_g == 1});
            chk("rd_gnt", {31'd0, rd_gnt}, {31'd0, e_g == 2});
            chk("owner", {30'd0, owner}, 32'(m_owner));
            chk("ram_wren", {31'd0, ram_wren}, {31'd0, e_wren});
            chk("ram_addr", {16'd0, ram_addr}, {16'd0, e_addr});
            if (e_wren) chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, e_wdata});
            if (rdq_cyc.size() > 0 && rdq_cyc[0] + 2 == cyc) begin
                chk("rd_valid", {31'd0, rd_valid}, 32'd1);
                chk("rd_data", {24'd0, rd_data}, {24'd0, rdq_dat[0]});
                void'(rdq_cyc.pop_front());
                void'(rdq_dat.pop_front());
            end else begin
                chk("rd_valid", {31'd0, rd_valid}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literal expectations
    // ------------------------------------------------------------------
    logic       cap_gw, cap_gr, cap_v;
    logic [7:0] cap_d;
    logic [1:0] cap_own;

    task automatic step(input logic r, input logic wq, input logic [15:0] wa,
                        input logic [7:0] wd, input logic rq, input logic [15:0] ra);
        reset   = r;
        wr_req  = wq;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = rq;
        rd_addr = ra;
        @(negedge clk);
        cap_gw  = wr_gnt;
        cap_gr  = rd_gnt;
        cap_v   = rd_valid;
        cap_d   = rd_data;
        cap_own = owner;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
    endtask

    string seq;
    string seq_exp;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i] = 8'(i) ^ 8'h5A;
            m_mem[i]  = 8'(i) ^ 8'h5A;
        end
        tb_mem[16'h0010] = 8'h3C;
        m_mem[16'h0010]  = 8'h3C;

        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset then idle
        step(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("idle_owner", {30'd0, cap_own}, 32'd0);
            chk("idle_wren", {31'd0, ram_wren}, 32'd0);
            chk("idle_rd_valid", {31'd0, cap_v}, 32'd0);
        end

        // Write only
        step(1'b0, 1'b1, 16'h0005, 8'hA5, 1'b0, 16'h0);
        chk("wr_only_gnt", {31'd0, cap_gw}, 32'd1);
        chk("wr_only_addr", {16'd0, ram_addr}, 32'h0005);
        chk("wr_only_wdata", {24'd0, ram_wdata}, 32'hA5);
        chk("wr_only_wren", {31'd0, ram_wren}, 32'd1);
        chk("wr_only_owner", {30'd0, owner}, 32'd1);
        idle();

        // Read only, latency 2
        step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0010);
        chk("rd_only_gnt", {31'd0, cap_gr}, 32'd1);
        idle();
        chk("rd_only_n1_valid", {31'd0, cap_v}, 32'd0);
        idle();
        chk("rd_only_n2_valid", {31'd0, cap_v}, 32'd1);
        chk("rd_only_n2_data", {24'd0, cap_d}, 32'h3C);
        idle();
        chk("rd_only_n3_valid", {31'd0, cap_v}, 32'd0);

        // Contention from IDLE
        seq = "";
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 16'(16'h0100 + i), 8'(i + 1), 1'b1, 16'(16'h0200 + i));
            chk("contend_one_hot", {31'd0, cap_gw & cap_gr}, 32'd0);
            seq = {seq, cap_gw ? "W" : (cap_gr ? "R" : "-")};
        end
`ifdef WRAM_ARB_FIXED_PRIO_EN
        seq_exp = "WWWWWWWWWWWW";
`else
        seq_exp = "WWWWRRRRWWWW";
`endif
        checks++;
        if (seq != seq_exp) begin
            errors++;
            $display("FAIL contend_pattern: got %s expected %s", seq, seq_exp);
        end
        idle(); idle(); idle();

        // Write then read of the same address on consecutive cycles
        step(1'b0, 1'b1, 16'h1234, 8'h77, 1'b0, 16'h0);
        chk("wtr_wr_gnt", {31'd0, cap_gw}, 32'd1);
        step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h1234);
        chk("wtr_rd_gnt", {31'd0, cap_gr}, 32'd1);
        idle();
        idle();
        chk("wtr_valid", {31'd0, cap_v}, 32'd1);
        chk("wtr_data", {24'd0, cap_d}, 32'h77);
        idle();

        // Reset in the middle of a read
        step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0010);
        chk("mid_rst_gnt", {31'd0, cap_gr}, 32'd1);
        step(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
        idle();
        chk("mid_rst_no_valid", {31'd0, cap_v}, 32'd0);
        chk("mid_rst_owner", {30'd0, cap_own}, 32'd0);

        // Mixed directed pattern over a small address window; some
        // requests drop before being granted
        for (int i = 0; i < 48; i++) begin
            step(1'b0, (i % 3) != 0, 16'(16'h0400 + (i % 8)), 8'(i * 7 + 1),
                 (i % 4) != 1, 16'(16'h0400 + ((i + 3) % 8)));
        end
        // Uncontended write grant followed by contention: the restart of
        // the run means exactly MAX_HOLD writes before the first read
        idle();
        step(1'b0, 1'b1, 16'h0500, 8'h11, 1'b0, 16'h0);
        seq = "";
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 16'(16'h0501 + i), 8'(i), 1'b1, 16'h0500);
            seq = {seq, cap_gw ? "W" : (cap_gr ? "R" : "-")};
        end
`ifdef WRAM_ARB_FIXED_PRIO_EN
        seq_exp = "WWWWW";
`else
        seq_exp = "WWWRR";
`endif
        checks++;
        if (seq != seq_exp) begin
            errors++;
            $display("FAIL restart_pattern: got %s expected %s", seq, seq_exp);
        end
        for (int i = 0; i < 4; i++) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
